// File: rtl/seg_scan_ctrl.sv
// Seven-segment digit scanner: guard/show timing per digit, frame-synchronous double buffering.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_ctrl #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DIV    = 1000,
  parameter int unsigned GUARD  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic                  load_i,
  output logic [3:0]            char_o,
  output logic [DIGITS-1:0]     an_n_o,
  output logic                  frame_start_o
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [15:0] DIV_LAST   = 16'(DIV - 1);
  localparam logic [15:0] GUARD_LAST = (GUARD > 0) ? 16'(GUARD - 1) : 16'd0;
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  typedef enum logic {GUARD_ST, SHOW_ST} state_e;
  localparam state_e RESET_ST = (GUARD == 0) ? SHOW_ST : GUARD_ST;

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] staged_q, staged_d;
  logic                pending_q, pending_d;
  logic [3:0]          char_q, char_d;
  logic [DIGITS-1:0]   an_n_q, an_n_d;
  logic                fs_q, fs_d;
  logic                wrap;
  logic [DIGITS-1:0]   blank;

  // Outputs are computed from next-state values so they change on the same edge as the FSM.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    staged_d  = staged_q;
    pending_d = pending_q;
    wrap      = 1'b0;

    case (state_q)
      GUARD_ST: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = SHOW_ST;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = 16'd0;
          state_d = (GUARD == 0) ? SHOW_ST : GUARD_ST;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
    endcase

    if (load_i) begin
      staged_d  = value_i;
      pending_d = 1'b1;
    end

    // A load arriving on the wrap edge bypasses the stage so the newest value is shown.
    if (wrap) begin
      if (load_i) begin
        shadow_d  = value_i;
        pending_d = 1'b0;
      end else if (pending_q) begin
        shadow_d  = staged_q;
        pending_d = 1'b0;
      end
    end

    blank = '0;
`ifdef SEG_SCAN_LZB_EN
    begin
      logic allZero;
      allZero = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        allZero  = allZero & (shadow_d[4*i +: 4] == 4'd0);
        blank[i] = allZero;
      end
    end
`endif

    char_d = shadow_d[{idx_d, 2'b00} +: 4];
    an_n_d = '1;
    if (state_d == SHOW_ST && !blank[idx_d]) begin
      an_n_d[idx_d] = 1'b0;
    end
    fs_d = wrap;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RESET_ST;
      idx_q     <= '0;
      cnt_q     <= 16'd0;
      shadow_q  <= '0;
      staged_q  <= '0;
      pending_q <= 1'b0;
      char_q    <= 4'd0;
      an_n_q    <= '1;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      staged_q  <= staged_d;
      pending_q <= pending_d;
      char_q    <= char_d;
      an_n_q    <= an_n_d;
      fs_q      <= fs_d;
    end
  end

  assign char_o        = char_q;
  assign an_n_o        = an_n_q;
  assign frame_start_o = fs_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed test-plan scenarios plus random loads,
// checked each cycle against a frame-position model derived from elapsed cycle count.
module tb_seg_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int GUARD  = 1;
  localparam int P      = GUARD + DIV;
  localparam int FRAME  = DIGITS * P;

  logic        clk = 1'b0;
  logic        rstN;
  logic [15:0] value;
  logic        load;
  logic [3:0]  charOut;
  logic [3:0]  anN;
  logic        frameStart;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: position in the scan follows from the number of edges since reset.
  int          t;
  logic [15:0] mShadow;
  logic [15:0] mStaged;
  logic        mPending;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .GUARD(GUARD)) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .value_i      (value),
    .load_i       (load),
    .char_o       (charOut),
    .an_n_o       (anN),
    .frame_start_o(frameStart)
  );

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checkCount++;
    if (obs !== exp) begin
      $display("[TB] FAIL %s at t=%0d (%0t): got %0h expected %0h", tag, t, $time, obs, exp);
    end else begin
      passCount++;
    end
  endtask

  function automatic logic leadBlank(input int d);
`ifdef SEG_SCAN_LZB_EN
    if (d == 0) return 1'b0;
    for (int i = d; i < DIGITS; i++) begin
      if (((mShadow >> (4 * i)) & 16'hF) != 16'd0) return 1'b0;
    end
    return 1'b1;
`else
    return (d < 0);
`endif
  endfunction

  task automatic modelReset();
    t        = 0;
    mShadow  = 16'd0;
    mStaged  = 16'd0;
    mPending = 1'b0;
  endtask

  task automatic modelEdge(input logic ld, input logic [15:0] v);
    t++;
    if (t % FRAME == 0) begin
      if (ld) begin
        mShadow  = v;
        mPending = 1'b0;
      end else if (mPending) begin
        mShadow  = mStaged;
        mPending = 1'b0;
      end
    end else if (ld) begin
      mStaged  = v;
      mPending = 1'b1;
    end
  endtask

  task automatic checkModel();
    int          o;
    int          d;
    logic [3:0]  expAn;
    logic [15:0] expChar;
    o       = t % P;
    d       = (t / P) % DIGITS;
    expAn   = 4'hF;
    if (o >= GUARD && !leadBlank(d)) expAn[d] = 1'b0;
    expChar = (mShadow >> (4 * d)) & 16'hF;
    checkOutput("an_n", {12'd0, anN}, {12'd0, expAn});
    checkOutput("char", {12'd0, charOut}, expChar);
    checkOutput("frame_start", {15'd0, frameStart}, {15'd0, (t > 0) && (t % FRAME == 0)});
  endtask

  task automatic applyStimulus(input logic ld, input logic [15:0] v);
    load  = ld;
    value = v;
    @(posedge clk);
    modelEdge(ld, v);
    #1;
    checkModel();
    load = 1'b0;
  endtask

  // Idle until the next edge is at frame position 'phase' (bounded to one frame).
  task automatic runUntil(input int phase);
    for (int k = 0; k < FRAME && ((t + 1) % FRAME) != phase; k++) begin
      applyStimulus(1'b0, 16'd0);
    end
  endtask

  initial begin
    rstN  = 1'b0;
    load  = 1'b0;
    value = 16'd0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkModel();
    rstN = 1'b1;
    checkModel();

    // Scan order over two frames
    applyStimulus(1'b1, 16'h4321);
    repeat (2 * FRAME) applyStimulus(1'b0, 16'd0);

    // Mid-frame load must not tear the current frame
    runUntil(8);
    applyStimulus(1'b1, 16'hAAAA);
    repeat (FRAME + 5) applyStimulus(1'b0, 16'd0);

    // Load on the wrap edge beats the pending stage
    runUntil(10);
    applyStimulus(1'b1, 16'h1111);
    runUntil(0);
    applyStimulus(1'b1, 16'h2222);
    repeat (2 * FRAME) applyStimulus(1'b0, 16'd0);

    // Last of several loads in one frame wins
    runUntil(3);
    applyStimulus(1'b1, 16'h0005);
    repeat (3) applyStimulus(1'b0, 16'd0);
    applyStimulus(1'b1, 16'h0006);
    repeat (3) applyStimulus(1'b0, 16'd0);
    applyStimulus(1'b1, 16'h0007);
    repeat (FRAME + 4) applyStimulus(1'b0, 16'd0);

    // Leading-zero patterns
    runUntil(5);
    applyStimulus(1'b1, 16'h0070);
    repeat (FRAME + 2) applyStimulus(1'b0, 16'd0);
    runUntil(5);
    applyStimulus(1'b1, 16'h0000);
    repeat (FRAME + 2) applyStimulus(1'b0, 16'd0);

    // Random loads
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) applyStimulus(1'b1, 16'($urandom));
      else applyStimulus(1'b0, 16'd0);
    end

    // Mid-SHOW asynchronous reset with an uncommitted staged value
    runUntil(3);
    applyStimulus(1'b1, 16'h9999);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("rst_an_n", {12'd0, anN}, 16'h000F);
    checkOutput("rst_char", {12'd0, charOut}, 16'h0000);
    checkOutput("rst_frame_start", {15'd0, frameStart}, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    modelReset();
    checkModel();
    repeat (2 * FRAME) applyStimulus(1'b0, 16'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing controller that shares one active-low seven-segment decoder across several common-anode digits. Cycles a digit index at a programmable dwell rate, presents that digit's 4-bit code on `char` for the downstream decoder, and drives one active-low digit enable at a time. A guard interval between digits prevents ghosting. Frame-synchronous double buffering prevents tearing.

## Interface
- `DIGITS`, 4: number of digits, 2..8.
- `DIV`, 1000: SHOW dwell per digit in clk cycles, ≥1, <2^16.
- `GUARD`, 2: blanking cycles before each digit, 0..255; 0 removes the GUARD state.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `value`  in  4*DIGITS  digit codes; `value[3:0]` is digit 0, the rightmost.
- `load`  in  1  one-cycle strobe that stages `value`.
- `char`  out  4  code of the current digit, to the decoder's `char` input.
- `an_n`  out  DIGITS  active-low digit enables; at most one bit low.
- `frame_start`  out  1  one-cycle pulse when the index wraps to 0.

## Operation
- Registers:
  - `staged` (4*DIGITS) and `pending`, for the load buffer.
  - `shadow` (4*DIGITS), the displayed value.
  - `idx` (clog2 DIGITS), the current digit.
  - `cnt` (16 bit), the dwell counter.
  - `state` ∈ {GUARD, SHOW}.
- GUARD:
  - `an_n` all ones; `char` = `shadow[idx]`.
  - Counts GUARD cycles, then goes to SHOW with `cnt` cleared.
- SHOW:
  - `an_n[idx]`=0; `char` = `shadow[idx]`.
  - Counts DIV cycles.
  - Then `idx` advances (DIGITS-1 wraps to 0), `an_n` returns to all ones, and the FSM enters GUARD (or SHOW again when GUARD=0).
- Load:
  - `load`=1 sets `staged`←`value` and `pending`←1.
  - Repeated loads before a commit overwrite `staged`; the last one wins.
- Commit:
  - Happens on the edge where `idx` wraps to 0, and only if `pending`=1.
  - `shadow`←`staged`, `pending`←0.
  - If `load`=1 on that same edge, `shadow`←`value` directly and `pending`←0. The newest value always wins.
- `frame_start` is high for the first cycle after the wrap edge. `char` in that cycle already reflects the committed `shadow`.
- No other input affects the FSM. `load` never restarts the scan.

## Timing
- Reset values (asynchronous on `rst_n`=0):
  - `state`=GUARD (SHOW if GUARD=0), `idx`=0, `cnt`=0.
  - `shadow`=0, `staged`=0, `pending`=0.
  - `an_n`=all ones, `char`=0, `frame_start`=0.
- All outputs are registered; nothing is combinational from inputs to outputs.
- After reset release:
  - First SHOW cycle for digit 0 is at cycle GUARD+1.
  - Digit period is GUARD+DIV cycles; frame period is DIGITS*(GUARD+DIV).
- Load-to-display latency:
  - Minimum 1 cycle (load on the commit edge).
  - Maximum one full frame.
- Mid-operation reset: outputs go to reset values immediately, and the staged value is lost.
- `cnt` wrap is impossible by construction; it is compared against DIV-1 or GUARD-1 and cleared.

## Configuration
- `SEG_SCAN_LZB_EN` (leading-zero blanking).
- Defined:
  - In SHOW, digit i>0 keeps `an_n[i]`=1 when `shadow` nibbles DIGITS-1..i are all 0.
  - Digit 0 is never blanked.
  - Timing and `char` are unchanged.
- Undefined: every digit is enabled in its SHOW slot regardless of value.

## Test plan
All scenarios use DIGITS=4, DIV=4, GUARD=1.
- **Reset:** assert `rst_n`=0 mid-SHOW → same cycle `an_n`=4'b1111, `char`=0, `frame_start`=0. After release, `an_n`=4'b1110 first appears at cycle 2.
- **Scan order:** `load` 16'h4321 then free-run 2 frames.
  - Enables run 1110→1101→1011→0111, each low for 4 cycles with 1 all-ones cycle between.
  - `char` = 1,2,3,4 matching each enable.
  - `frame_start` every 20 cycles.
- **Tear-free:** `load` 16'hAAAA mid-frame while showing 16'h4321.
  - Remaining digits of that frame still show 3,4.
  - 'A' first appears after the next `frame_start`.
- **Simultaneous load/commit:**
  - Pending 16'h1111, with `load` 16'h2222 on the wrap edge → next frame shows 2222, `pending`=0.
  - A frame later there is no further change.
- **Multiple loads:** loads 16'h0005, then 16'h0006, then 16'h0007 in one frame → next frame shows 0007 only.
- **`SEG_SCAN_LZB_EN` defined:**
  - 16'h0070 → digits 3 and 2 remain dark during SHOW; digits 1 and 0 are enabled with `char` 7 and 0.
  - 16'h0000 → only digit 0 is enabled.
